// File: rtl/i2c_color_target.sv
// I2C target emulating the colour sensor: samples open-drain SCL/SDA on clk_i,
// decodes address/command/data and serves a small register map with colour shadowing.
module i2c_color_target #(
  parameter logic [6:0]  DEV_ADDR    = 7'h29,
  parameter logic [7:0]  ID_VAL      = 8'h44,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  input  logic [15:0] cdata_i,
  input  logic [15:0] rdata_i,
  input  logic [15:0] gdata_i,
  input  logic [15:0] bdata_i,
  input  logic        data_valid_i,
  output logic [7:0]  enable_o,
  output logic [7:0]  atime_o,
  output logic        wr_stb_o,
  output logic        busy_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK, CMD, WDATA, RDATA, RSTART, RACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;
  logic                   start_evt, stop_evt, scl_rise, scl_fall;

  state_t      state_q, ack_nxt_q;
  logic [6:0]  sh_q;
  logic [2:0]  cnt_q;
  logic [7:0]  tx_q;
  logic [4:0]  ptr_q;
  logic        ai_q;
  logic        ack_drv_q;
  logic [7:0]  enable_q, atime_q;
  logic [55:0] shadow_q;
  logic        sda_oe_q, wr_stb_q, busy_q;

  logic [7:0]  byte_d;
  logic [4:0]  ld_ptr_d;
  logic [7:0]  rd_byte_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign start_evt = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_evt  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;

  assign byte_d   = {sh_q, sda_s};
  // On a read ACK the next byte comes from the already-advanced pointer.
  assign ld_ptr_d = ptr_q + {4'b0, (state_q == RACK) & ai_q};

  always_comb begin
    rd_byte_d = 8'h00;
    case (ld_ptr_d)
      5'h00:   rd_byte_d = enable_q;
      5'h01:   rd_byte_d = atime_q;
      5'h12:   rd_byte_d = ID_VAL;
      5'h13:   rd_byte_d = {7'b0, data_valid_i};
      5'h14:   rd_byte_d = cdata_i[7:0];
      5'h15:   rd_byte_d = shadow_q[7:0];
      5'h16:   rd_byte_d = shadow_q[15:8];
      5'h17:   rd_byte_d = shadow_q[23:16];
      5'h18:   rd_byte_d = shadow_q[31:24];
      5'h19:   rd_byte_d = shadow_q[39:32];
      5'h1A:   rd_byte_d = shadow_q[47:40];
      5'h1B:   rd_byte_d = shadow_q[55:48];
      default: rd_byte_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ack_nxt_q <= IDLE;
      sh_q      <= '0;
      cnt_q     <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      ai_q      <= 1'b0;
      ack_drv_q <= 1'b0;
      enable_q  <= 8'h00;
      atime_q   <= 8'hFF;
      shadow_q  <= '0;
      sda_oe_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      wr_stb_q <= 1'b0;
      if (start_evt) begin
        state_q  <= ADDR;
        cnt_q    <= '0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (stop_evt) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          ADDR: if (scl_rise) begin
            sh_q  <= byte_d[6:0];
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (byte_d[7:1] == DEV_ADDR) begin
                state_q   <= ACK;
                ack_drv_q <= 1'b0;
                busy_q    <= 1'b1;
                if (byte_d[0]) begin
                  ack_nxt_q <= RDATA;
                  tx_q      <= rd_byte_d;
                  if (ld_ptr_d == 5'h14)
                    shadow_q <= {bdata_i, gdata_i, rdata_i, cdata_i[15:8]};
                end else begin
                  ack_nxt_q <= CMD;
                end
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          ACK: if (scl_fall) begin
            // First fall starts the ACK bit, second fall ends it.
            if (!ack_drv_q) begin
              sda_oe_q  <= 1'b1;
              ack_drv_q <= 1'b1;
            end else begin
              ack_drv_q <= 1'b0;
              cnt_q     <= '0;
              state_q   <= ack_nxt_q;
              sda_oe_q  <= (ack_nxt_q == RDATA) ? ~tx_q[7] : 1'b0;
            end
          end
          CMD: if (scl_rise) begin
            sh_q  <= byte_d[6:0];
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (byte_d[7]) begin
                ptr_q     <= byte_d[4:0];
                ai_q      <= (byte_d[6:5] == 2'b01);
                state_q   <= ACK;
                ack_nxt_q <= WDATA;
                ack_drv_q <= 1'b0;
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          WDATA: if (scl_rise) begin
            sh_q  <= byte_d[6:0];
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (ptr_q == 5'h00) begin
                enable_q <= byte_d;
                wr_stb_q <= 1'b1;
              end else if (ptr_q == 5'h01) begin
                atime_q  <= byte_d;
                wr_stb_q <= 1'b1;
              end
              ptr_q     <= ptr_q + {4'b0, ai_q};
              state_q   <= ACK;
              ack_nxt_q <= WDATA;
              ack_drv_q <= 1'b0;
            end
          end
          RDATA: if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              sda_oe_q <= 1'b0;
              state_q  <= RACK;
            end else begin
              sda_oe_q <= ~tx_q[6];
              tx_q     <= tx_q << 1;
              cnt_q    <= cnt_q + 3'd1;
            end
          end
          RACK: if (scl_rise) begin
            if (!sda_s) begin
              ptr_q   <= ld_ptr_d;
              tx_q    <= rd_byte_d;
              state_q <= RSTART;
              if (ld_ptr_d == 5'h14)
                shadow_q <= {bdata_i, gdata_i, rdata_i, cdata_i[15:8]};
            end else begin
              state_q <= IGNORE;
            end
          end
          RSTART: if (scl_fall) begin
            sda_oe_q <= ~tx_q[7];
            cnt_q    <= '0;
            state_q  <= RDATA;
          end
          default: sda_oe_q <= 1'b0;
        endcase
      end
    end
  end

  assign sda_oe_o = sda_oe_q;
  assign enable_o = enable_q;
  assign atime_o  = atime_q;
  assign wr_stb_o = wr_stb_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_i2c_color_target.sv
// Bench for i2c_color_target: bit-banged I2C master plus a register-map model
// built from the documented access rules.
module tb_i2c_color_target;

  localparam int Q = 8;

  logic        clk, rst;
  logic        scl_m, sda_m, sda_line;
  logic        sda_oe;
  logic [15:0] cdata, rdata, gdata, bdata;
  logic        dvalid;
  logic [7:0]  enable, atime;
  logic        wr_stb, busy;

  int ncmp = 0;
  int nfail = 0;
  int stb_cnt = 0;
  int oe_cnt = 0;

  logic [7:0]  m_en, m_at;
  logic [4:0]  m_ptr;
  logic        m_ai;
  logic [63:0] m_sh;
  int          exp_stb;

  assign sda_line = sda_m & ~sda_oe;

  i2c_color_target #(.DEV_ADDR(7'h29), .ID_VAL(8'h44), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl_m), .sda_i(sda_line), .sda_oe_o(sda_oe),
    .cdata_i(cdata), .rdata_i(rdata), .gdata_i(gdata), .bdata_i(bdata),
    .data_valid_i(dvalid), .enable_o(enable), .atime_o(atime),
    .wr_stb_o(wr_stb), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_stb) stb_cnt <= stb_cnt + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); sda_m = 1'b0; wq(); scl_m = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq(); scl_m = 1'b1; wq(); sda_m = 1'b1; wq();
  endtask

  task automatic wbit(input logic b);
    sda_m = b; wq(); scl_m = 1'b1; wq(); wq(); scl_m = 1'b0; wq();
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); b = sda_line; wq(); scl_m = 1'b0; wq();
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask

  task automatic rbyte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
  endtask

  task automatic m_reset();
    m_en = 8'h00; m_at = 8'hFF; m_ptr = 5'h00; m_ai = 1'b0; m_sh = '0;
  endtask

  task automatic m_cmd(input logic [7:0] c);
    if (c[7]) begin
      m_ptr = c[4:0];
      m_ai  = (c[6:5] == 2'b01);
    end
  endtask

  task automatic m_write(input logic [7:0] d);
    if (m_ptr == 5'h00) begin m_en = d; exp_stb++; end
    else if (m_ptr == 5'h01) begin m_at = d; exp_stb++; end
    m_ptr = m_ptr + 5'(m_ai);
  endtask

  task automatic m_load(output logic [7:0] v);
    logic [63:0] live;
    int k;
    live = {bdata, gdata, rdata, cdata};
    k = int'(m_ptr) - 'h14;
    v = 8'h00;
    if (m_ptr == 5'h00) v = m_en;
    else if (m_ptr == 5'h01) v = m_at;
    else if (m_ptr == 5'h12) v = 8'h44;
    else if (m_ptr == 5'h13) v = {7'b0, dvalid};
    else if (k == 0) begin m_sh = live; v = live[7:0]; end
    else if (k > 0 && k < 8) v = m_sh[8*k +: 8];
  endtask

  task automatic wr_regs(input logic [7:0] c, input logic [7:0] d0, input logic [7:0] d1, input int n);
    logic ack;
    logic [7:0] d;
    i2c_start();
    wbyte(8'h52, ack); chk("wr_addr_ack", ack, 0);
    wbyte(c, ack);     chk($sformatf("wr_cmd%02h_ack", c), ack, c[7] ? 0 : 1);
    m_cmd(c);
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? d0 : d1;
      wbyte(d, ack);
      chk($sformatf("wr_data%0d_ack", i), ack, c[7] ? 0 : 1);
      if (c[7]) m_write(d);
    end
    i2c_stop();
    chk("wr_enable", enable, m_en);
    chk("wr_atime", atime, m_at);
    chk("wr_stb_count", stb_cnt, exp_stb);
    chk("wr_busy_after_stop", busy, 0);
  endtask

  // Reads n bytes after a repeated START; colour inputs change after byte chg_at.
  task automatic rd_regs(input logic [7:0] c, input int n, input int chg_at, input bit rnd_chg);
    logic ack;
    logic [7:0] b, e;
    i2c_start();
    wbyte(8'h52, ack); chk("rd_addr_w_ack", ack, 0);
    wbyte(c, ack);     chk($sformatf("rd_cmd%02h_ack", c), ack, 0);
    m_cmd(c);
    i2c_start();
    wbyte(8'h53, ack); chk("rd_addr_r_ack", ack, 0);
    m_load(e);
    for (int i = 0; i < n; i++) begin
      rbyte(b);
      chk($sformatf("rd_cmd%02h_byte%0d", c, i), b, e);
      if (i == chg_at) begin
        if (rnd_chg) begin
          cdata = 16'($urandom); rdata = 16'($urandom);
          gdata = 16'($urandom); bdata = 16'($urandom);
        end else begin
          cdata = 16'hFFFF;
        end
      end
      if (i == n - 1) begin
        wbit(1'b1);
        chk("rd_release_after_nack", sda_oe, 0);
      end else begin
        wbit(1'b0);
        m_ptr = m_ptr + 5'(m_ai);
        m_load(e);
      end
    end
    i2c_stop();
    chk("rd_busy_after_stop", busy, 0);
  endtask

  initial begin
    logic ack;
    int oe0;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    cdata = '0; rdata = '0; gdata = '0; bdata = '0; dvalid = 1'b0;
    exp_stb = 0;
    m_reset();
    repeat (4) @(negedge clk);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enable", enable, 8'h00);
    chk("rst_atime", atime, 8'hFF);
    rst = 1'b0;
    wq();

    // Plain write of ENABLE, with busy observed mid-frame
    i2c_start();
    wbyte(8'h52, ack); chk("t1_addr_ack", ack, 0);
    chk("t1_busy", busy, 1);
    wbyte(8'h80, ack); chk("t1_cmd_ack", ack, 0);
    m_cmd(8'h80);
    wbyte(8'h03, ack); chk("t1_data_ack", ack, 0);
    m_write(8'h03);
    i2c_stop();
    chk("t1_enable", enable, 8'h03);
    chk("t1_stb", stb_cnt, 1);
    chk("t1_busy_low", busy, 0);

    // ID read with NACK
    rd_regs(8'h92, 1, -1, 1'b0);

    // Coherent colour burst: cdata changes after the first byte
    cdata = 16'h1234; rdata = 16'hABCD;
    rd_regs(8'hB4, 4, 0, 1'b0);

    // Foreign address: SDA never pulled
    oe0 = oe_cnt;
    i2c_start();
    wbyte(8'h60, ack); chk("t4_addr_nack", ack, 1);
    wbyte(8'h80, ack); chk("t4_cmd_nack", ack, 1);
    i2c_stop();
    chk("t4_oe_never", oe_cnt - oe0, 0);
    chk("t4_busy", busy, 0);

    // Command byte without bit7: NACK and ignore the data
    wr_regs(8'h01, 8'h55, 8'h00, 1);

    // Reset while the target holds the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) wbit(1'(8'h52 >> i));
    sda_m = 1'b1;
    for (int i = 0; i < 40 && !sda_oe; i++) @(negedge clk);
    chk("t6_ack_driven", sda_oe, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_sda_oe", sda_oe, 0);
    chk("t6_rst_enable", enable, 8'h00);
    chk("t6_rst_atime", atime, 8'hFF);
    chk("t6_rst_busy", busy, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    wq(); wq();
    wr_regs(8'h80, 8'h5A, 8'h00, 1);

    // Randomized traffic against the model
    for (int it = 0; it < 4; it++) begin
      wr_regs(8'hA0, 8'($urandom), 8'($urandom), 2);
      wr_regs(8'h92, 8'($urandom), 8'h00, 1);
      cdata = 16'($urandom); rdata = 16'($urandom);
      gdata = 16'($urandom); bdata = 16'($urandom);
      dvalid = 1'($urandom);
      rd_regs(8'hB2, 10, int'($urandom_range(2, 8)), 1'b1);
      rd_regs(8'hBF, 2, -1, 1'b0);
      rd_regs(8'h81, 3, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/i2c_color_target.md
Name: i2c_color_target

Overview:
- Synthesizable I2C target (slave) that emulates the colour sensor on the other end of the I2C master in pmod_color.
- Lets the master be simulated and hardware-looped without a physical Pmod.
- Samples open-drain SCL/SDA with the system clock, decodes address/command/data, and serves a small register map.
- Colour registers are fed from parallel inputs.

Parameters:
- DEV_ADDR, 7'h29, 7-bit device address matched.
- ID_VAL, 8'h44, value returned by ID register 0x12.
- SYNC_STAGES, 2, flops per synchronizer on scl_i/sda_i (>=2).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- scl_i  in  1  SCL line level (async)
- sda_i  in  1  SDA line level (async)
- sda_oe_o  out  1  1 = pull SDA low; 0 = release
- cdata_i  in  16  clear channel sample
- rdata_i  in  16  red channel sample
- gdata_i  in  16  green channel sample
- bdata_i  in  16  blue channel sample
- data_valid_i  in  1  samples valid (STATUS bit0)
- enable_o  out  8  register 0x00 contents
- atime_o  out  8  register 0x01 contents
- wr_stb_o  out  1  1-cycle pulse per accepted register write
- busy_o  out  1  1 while addressed (ADDR_ACK through STOP/START)

Behaviour:
- Reset: sda_oe_o=0, wr_stb_o=0, busy_o=0, enable_o=8'h00, atime_o=8'hFF, pointer=0, auto-increment=0, state IDLE. Synchronizer flops reset to 1.
- Events on synchronized lines, edge detect vs previous sample:
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
  - Bits sampled on SCL rise. SDA driven/changed one clk after SCL fall is detected.
- START/STOP are honoured in any state and override bit activity.
  - START (incl. repeated) -> ADDR, bit counter cleared, sda_oe_o=0.
  - STOP -> IDLE, sda_oe_o=0, busy_o=0.
- FSM:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first. On the 8th bit: if addr==DEV_ADDR -> ADDR_ACK, else IGNORE (never drive SDA until next START/STOP).
  - ADDR_ACK: drive 0 for the ack clock, release after its SCL fall. Then R/W=0 -> CMD, R/W=1 -> RDATA (load byte at pointer).
  - CMD: 8 bits. Bit7 must be 1, else NACK (release SDA) and go to IGNORE. Otherwise pointer=bits[4:0], auto-increment = (bits[6:5]==2'b01), ACK -> WDATA.
  - WDATA: 8 bits -> write pointer register if writable, wr_stb_o pulse on the cycle the 8th bit is sampled. ACK always. Pointer increments if auto-increment.
  - RDATA: drive MSB after the ACK fall, next bit after each SCL fall. After 8 bits release SDA -> RACK.
  - RACK: sample master bit on SCL rise. ACK(0) -> pointer++ if auto-increment, load next byte -> RDATA. NACK(1) -> IGNORE until STOP/START.
- Register map (pointer 5 bits, wraps 0x1F->0x00):
  - 0x00 enable rw; 0x01 atime rw.
  - 0x12 ID (ro).
  - 0x13 STATUS = {7'b0, data_valid_i} (ro).
  - 0x14/15 cdata L/H, 0x16/17 rdata L/H, 0x18/19 gdata L/H, 0x1A/1B bdata L/H.
  - Any other address: reads 8'h00, writes ignored (still ACKed, no wr_stb_o).
- Shadowing: reading 0x14 latches all 64 data bits. Reads 0x15-0x1B return the latched copy, so L/H pairs are coherent.
- Writes on the same cycle as a data-input change are unaffected (separate regs).
- Reset mid-transfer: immediate return to reset values, SDA released same cycle.

Test Plan:
- Write 0x52 (addr 0x29,W), cmd 0x80, data 0x03 -> all three ACKed, enable_o=8'h03, one wr_stb_o pulse, busy_o low after STOP.
- Write cmd 0x92, repeated START, read 0x53, master NACK -> byte 0x44 returned, SDA released after NACK.
- cdata_i=16'h1234, rdata_i=16'hABCD; cmd 0xB4, repeated-START read of 4 bytes ACK,ACK,ACK,NACK; change cdata_i to 16'hFFFF after first byte -> bytes 0x34,0x12,0xCD,0xAB.
- Address 0x30 write -> no ACK (SDA high on 9th clock), sda_oe_o never asserted for the whole frame.
- Cmd 0x01 (bit7=0) -> NACK on cmd byte, following data ignored, enable_o unchanged.
- Assert rst_i while target drives ACK -> sda_oe_o=0 next edge, enable_o=0, atime_o=8'hFF, next transaction with START works normally.
